// File: rtl/pong_game_sequencer_if.sv
// Game-flow bus between the pong sequencer and the blocks that feed and consume it.
// The sequencer attaches through the slave modport; the driving side uses master.
interface pong_game_sequencer_if #(
    parameter int SCORE_W = 5
);
    logic               frame_tick;
    logic               launch;
    logic               time_mode;
    logic [SCORE_W-1:0] max_score;
    logic               time_out;
    logic               left_hit;
    logic               right_hit;
    logic [2:0]         state;
    logic [SCORE_W-1:0] score_p1;
    logic [SCORE_W-1:0] score_p2;
    logic               serve_player;
    logic               obj_reset;
    logic               play_en;
    logic               time_en;
    logic               time_reset;
    logic [1:0]         winner;

    modport master (
        output frame_tick, launch, time_mode, max_score, time_out, left_hit, right_hit,
        input  state, score_p1, score_p2, serve_player, obj_reset, play_en, time_en,
               time_reset, winner
    );

    modport slave (
        input  frame_tick, launch, time_mode, max_score, time_out, left_hit, right_hit,
        output state, score_p1, score_p2, serve_player, obj_reset, play_en, time_en,
               time_reset, winner
    );
endinterface

// File: rtl/pong_game_sequencer.sv
// Registered game-flow FSM for the VGA pong core: menu/set/start/play/end_point/end_game.
// Optional AUTO_SERVE_EN: start auto-serves after SERVE_FRAMES frame ticks without launch.
module pong_game_sequencer #(
    parameter int SCORE_W      = 5,
    parameter int HOLD_FRAMES  = 60,
    parameter int SERVE_FRAMES = 120
) (
    input  logic                  clk_pix,
    input  logic                  reset,
    pong_game_sequencer_if.slave  bus
);
    localparam logic [2:0] ST_MENU      = 3'd0;
    localparam logic [2:0] ST_SET       = 3'd1;
    localparam logic [2:0] ST_START     = 3'd2;
    localparam logic [2:0] ST_PLAY      = 3'd3;
    localparam logic [2:0] ST_END_POINT = 3'd4;
    localparam logic [2:0] ST_END_GAME  = 3'd5;

    localparam logic [7:0]         HOLD_LAST = 8'(HOLD_FRAMES - 1);
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic               r_launch_s1, r_launch_s2, r_launch_d;
    logic [2:0]         r_state;
    logic [7:0]         r_frame_cnt;
    logic [SCORE_W-1:0] r_score_p1, r_score_p2;
    logic               r_serve_player, r_obj_reset, r_play_en, r_time_en, r_time_reset;
    logic [1:0]         r_winner;

    logic       w_launch_edge;
    logic       w_match_over;
    logic       w_count_en;
    logic [2:0] w_state_nxt;

    assign w_launch_edge = r_launch_s2 & ~r_launch_d;

    assign w_match_over = (!bus.time_mode && (bus.max_score != '0) &&
                           ((r_score_p1 >= bus.max_score) || (r_score_p2 >= bus.max_score))) ||
                          (bus.time_mode && bus.time_out);

`ifdef AUTO_SERVE_EN
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    assign w_count_en = (r_state == ST_END_POINT) || (r_state == ST_START);
`else
    assign w_count_en = (r_state == ST_END_POINT);
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_MENU:  if (w_launch_edge) w_state_nxt = ST_SET;
            ST_SET:   if (w_launch_edge) w_state_nxt = ST_START;
            ST_START: begin
                if (w_launch_edge) w_state_nxt = ST_PLAY;
`ifdef AUTO_SERVE_EN
                else if (bus.frame_tick && (r_frame_cnt == SERVE_LAST)) w_state_nxt = ST_PLAY;
`endif
            end
            ST_PLAY: begin
                if (bus.right_hit || bus.left_hit)         w_state_nxt = ST_END_POINT;
                else if (bus.time_mode && bus.time_out)    w_state_nxt = ST_END_GAME;
            end
            ST_END_POINT: begin
                if (bus.frame_tick && (r_frame_cnt == HOLD_LAST))
                    w_state_nxt = w_match_over ? ST_END_GAME : ST_START;
            end
            ST_END_GAME: if (w_launch_edge) w_state_nxt = ST_MENU;
            default:  w_state_nxt = ST_MENU;
        endcase
    end

    always_ff @(posedge clk_pix) begin
        if (reset) begin
            r_launch_s1    <= 1'b0;
            r_launch_s2    <= 1'b0;
            r_launch_d     <= 1'b0;
            r_state        <= ST_MENU;
            r_frame_cnt    <= '0;
            r_score_p1     <= '0;
            r_score_p2     <= '0;
            r_serve_player <= 1'b0;
            r_obj_reset    <= 1'b0;
            r_play_en      <= 1'b0;
            r_time_en      <= 1'b0;
            r_time_reset   <= 1'b0;
            r_winner       <= 2'b00;
        end else begin
            r_launch_s1 <= bus.launch;
            r_launch_s2 <= r_launch_s1;
            r_launch_d  <= r_launch_s2;
            r_state     <= w_state_nxt;

            if (w_state_nxt != r_state)           r_frame_cnt <= '0;
            else if (w_count_en && bus.frame_tick) r_frame_cnt <= r_frame_cnt + 8'd1;

            r_time_reset <= (r_state == ST_SET) && (w_state_nxt == ST_START);
            r_obj_reset  <= (r_state != ST_START) && (w_state_nxt == ST_START);
            r_play_en    <= (w_state_nxt == ST_PLAY);
            r_time_en    <= (w_state_nxt == ST_PLAY) && bus.time_mode;

            // right wall hit means p1 scored; it wins a tie with a simultaneous left hit
            if ((r_state == ST_SET) && (w_state_nxt == ST_START)) begin
                r_score_p1     <= '0;
                r_score_p2     <= '0;
                r_serve_player <= 1'b0;
            end else if ((r_state == ST_PLAY) && bus.right_hit) begin
                if (r_score_p1 != SCORE_MAX) r_score_p1 <= r_score_p1 + SCORE_ONE;
                r_serve_player <= 1'b1;
            end else if ((r_state == ST_PLAY) && bus.left_hit) begin
                if (r_score_p2 != SCORE_MAX) r_score_p2 <= r_score_p2 + SCORE_ONE;
                r_serve_player <= 1'b0;
            end

            if ((r_state != ST_END_GAME) && (w_state_nxt == ST_END_GAME)) begin
                if (r_score_p1 > r_score_p2)      r_winner <= 2'b01;
                else if (r_score_p2 > r_score_p1) r_winner <= 2'b10;
                else                              r_winner <= 2'b11;
            end
        end
    end

    assign bus.state        = r_state;
    assign bus.score_p1     = r_score_p1;
    assign bus.score_p2     = r_score_p2;
    assign bus.serve_player = r_serve_player;
    assign bus.obj_reset    = r_obj_reset;
    assign bus.play_en      = r_play_en;
    assign bus.time_en      = r_time_en;
    assign bus.time_reset   = r_time_reset;
    assign bus.winner       = r_winner;
endmodule

// File: tb/tb_pong_game_sequencer.sv
// Directed bench for pong_game_sequencer with HOLD_FRAMES=4, SERVE_FRAMES=3.
module tb_pong_game_sequencer;
    logic clk_pix = 1'b0;
    logic reset   = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk_pix = ~clk_pix;

    pong_game_sequencer_if #(.SCORE_W(5)) bus ();

    pong_game_sequencer #(.SCORE_W(5), .HOLD_FRAMES(4), .SERVE_FRAMES(3)) dut (
        .clk_pix (clk_pix),
        .reset   (reset),
        .bus     (bus)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_pix);
            #1;
        end
    endtask

    // launch held 3 cycles: state has changed at return of the first cyc(3)
    task automatic press();
        bus.launch = 1'b1;
        cyc(3);
        bus.launch = 1'b0;
        cyc(3);
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        cyc(1);
        bus.frame_tick = 1'b0;
        cyc(1);
    endtask

    task automatic hit(input bit right);
        if (right) bus.right_hit = 1'b1; else bus.left_hit = 1'b1;
        cyc(1);
        bus.right_hit = 1'b0;
        bus.left_hit  = 1'b0;
    endtask

    task automatic round(input bit right);
        hit(right);
        repeat (4) tick();
        press();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(2);
        n_checks++;
        if (bus.state !== 3'd0 || bus.score_p1 !== 5'd0 || bus.score_p2 !== 5'd0 ||
            bus.serve_player !== 1'b0 || bus.winner !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_regs: state=%0d p1=%0d p2=%0d serve=%0d winner=%0d expected all 0",
                     bus.state, bus.score_p1, bus.score_p2, bus.serve_player, bus.winner);
        end
        n_checks++;
        if ({bus.obj_reset, bus.play_en, bus.time_en, bus.time_reset} !== 4'b0) begin
            n_errors++;
            $display("FAIL reset_strobes: got %b expected 0000",
                     {bus.obj_reset, bus.play_en, bus.time_en, bus.time_reset});
        end
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic test_launch_seq();
        bus.launch = 1'b1;
        cyc(2);
        n_checks++;
        if (bus.state !== 3'd0) begin
            n_errors++; $display("FAIL sync_latency: state=%0d expected 0", bus.state);
        end
        cyc(1);
        n_checks++;
        if (bus.state !== 3'd1) begin
            n_errors++; $display("FAIL menu_to_set: state=%0d expected 1", bus.state);
        end
        bus.launch = 1'b0;
        cyc(3);
        bus.launch = 1'b1;
        cyc(3);
        n_checks++;
        if (bus.state !== 3'd2 || bus.time_reset !== 1'b1 || bus.obj_reset !== 1'b1) begin
            n_errors++;
            $display("FAIL set_to_start: state=%0d time_reset=%0d obj_reset=%0d expected 2/1/1",
                     bus.state, bus.time_reset, bus.obj_reset);
        end
        bus.launch = 1'b0;
        cyc(1);
        n_checks++;
        if (bus.time_reset !== 1'b0 || bus.obj_reset !== 1'b0) begin
            n_errors++;
            $display("FAIL pulse_width: time_reset=%0d obj_reset=%0d expected 0/0",
                     bus.time_reset, bus.obj_reset);
        end
        cyc(2);
        press();
        n_checks++;
        if (bus.state !== 3'd3 || bus.play_en !== 1'b1 || bus.time_en !== 1'b0) begin
            n_errors++;
            $display("FAIL start_to_play: state=%0d play_en=%0d time_en=%0d expected 3/1/0",
                     bus.state, bus.play_en, bus.time_en);
        end
    endtask

    task automatic test_score_mode();
        bus.max_score = 5'd2;
        hit(1'b1);
        n_checks++;
        if (bus.state !== 3'd4 || bus.score_p1 !== 5'd1 || bus.serve_player !== 1'b1 ||
            bus.play_en !== 1'b0) begin
            n_errors++;
            $display("FAIL first_point: state=%0d p1=%0d serve=%0d play_en=%0d expected 4/1/1/0",
                     bus.state, bus.score_p1, bus.serve_player, bus.play_en);
        end
        press();
        repeat (3) tick();
        n_checks++;
        if (bus.state !== 3'd4) begin
            n_errors++; $display("FAIL hold_3_ticks: state=%0d expected 4", bus.state);
        end
        bus.frame_tick = 1'b1;
        cyc(1);
        bus.frame_tick = 1'b0;
        n_checks++;
        if (bus.state !== 3'd2 || bus.obj_reset !== 1'b1) begin
            n_errors++;
            $display("FAIL hold_to_start: state=%0d obj_reset=%0d expected 2/1",
                     bus.state, bus.obj_reset);
        end
        cyc(1);
        press();
        hit(1'b1);
        repeat (4) tick();
        n_checks++;
        if (bus.state !== 3'd5 || bus.score_p1 !== 5'd2 || bus.winner !== 2'b01 ||
            bus.serve_player !== 1'b1) begin
            n_errors++;
            $display("FAIL score_game_end: state=%0d p1=%0d winner=%0d serve=%0d expected 5/2/1/1",
                     bus.state, bus.score_p1, bus.winner, bus.serve_player);
        end
        press();
        n_checks++;
        if (bus.state !== 3'd0 || bus.score_p1 !== 5'd2) begin
            n_errors++;
            $display("FAIL end_to_menu: state=%0d p1=%0d expected 0/2", bus.state, bus.score_p1);
        end
    endtask

    task automatic test_simultaneous();
        press();
        press();
        n_checks++;
        if (bus.state !== 3'd2 || bus.score_p1 !== 5'd0) begin
            n_errors++;
            $display("FAIL score_clear: state=%0d p1=%0d expected 2/0", bus.state, bus.score_p1);
        end
        press();
        bus.right_hit = 1'b1;
        bus.left_hit  = 1'b1;
        cyc(1);
        bus.right_hit = 1'b0;
        bus.left_hit  = 1'b0;
        n_checks++;
        if (bus.state !== 3'd4 || bus.score_p1 !== 5'd1 || bus.score_p2 !== 5'd0) begin
            n_errors++;
            $display("FAIL both_hits: state=%0d p1=%0d p2=%0d expected 4/1/0",
                     bus.state, bus.score_p1, bus.score_p2);
        end
        hit(1'b0);
        cyc(1);
        n_checks++;
        if (bus.score_p2 !== 5'd0) begin
            n_errors++; $display("FAIL hit_outside_play: p2=%0d expected 0", bus.score_p2);
        end
        repeat (4) tick();
    endtask

    task automatic test_time_mode();
        bus.time_mode = 1'b1;
        press();
        n_checks++;
        if (bus.state !== 3'd3 || bus.time_en !== 1'b1) begin
            n_errors++;
            $display("FAIL time_en: state=%0d time_en=%0d expected 3/1", bus.state, bus.time_en);
        end
        round(1'b1);
        round(1'b0);
        round(1'b0);
        round(1'b1);
        bus.time_out = 1'b1;
        hit(1'b0);
        n_checks++;
        if (bus.state !== 3'd4 || bus.score_p2 !== 5'd3) begin
            n_errors++;
            $display("FAIL hit_over_timeout: state=%0d p2=%0d expected 4/3", bus.state, bus.score_p2);
        end
        bus.time_out = 1'b0;
        repeat (4) tick();
        press();
        bus.time_out = 1'b1;
        cyc(1);
        n_checks++;
        if (bus.state !== 3'd5 || bus.winner !== 2'b11 || bus.time_en !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_draw: state=%0d winner=%0d time_en=%0d expected 5/3/0",
                     bus.state, bus.winner, bus.time_en);
        end
        bus.time_out  = 1'b0;
        bus.time_mode = 1'b0;
        press();
    endtask

    task automatic test_launch_hold();
        bus.launch = 1'b1;
        cyc(1000);
        bus.launch = 1'b0;
        cyc(3);
        n_checks++;
        if (bus.state !== 3'd1) begin
            n_errors++; $display("FAIL launch_hold: state=%0d expected 1", bus.state);
        end
    endtask

    task automatic test_reset_mid();
        bus.max_score = 5'd0;
        press();
        press();
        repeat (6) round(1'b0);
        hit(1'b0);
        n_checks++;
        if (bus.state !== 3'd4 || bus.score_p2 !== 5'd7) begin
            n_errors++;
            $display("FAIL pre_reset: state=%0d p2=%0d expected 4/7", bus.state, bus.score_p2);
        end
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        n_checks++;
        if (bus.state !== 3'd0 || bus.score_p2 !== 5'd0 || bus.score_p1 !== 5'd0 ||
            {bus.obj_reset, bus.play_en, bus.time_en, bus.time_reset} !== 4'b0) begin
            n_errors++;
            $display("FAIL mid_reset: state=%0d p1=%0d p2=%0d strobes=%b expected 0/0/0/0000",
                     bus.state, bus.score_p1, bus.score_p2,
                     {bus.obj_reset, bus.play_en, bus.time_en, bus.time_reset});
        end
    endtask

    task automatic test_saturation();
        press();
        press();
        press();
        repeat (33) round(1'b1);
        n_checks++;
        if (bus.state !== 3'd3 || bus.score_p1 !== 5'd31) begin
            n_errors++;
            $display("FAIL saturate_unlimited: state=%0d p1=%0d expected 3/31",
                     bus.state, bus.score_p1);
        end
    endtask

    task automatic test_start_serve();
        hit(1'b1);
        repeat (4) tick();
        repeat (3) tick();
`ifdef AUTO_SERVE_EN
        n_checks++;
        if (bus.state !== 3'd3) begin
            n_errors++; $display("FAIL auto_serve: state=%0d expected 3", bus.state);
        end
`else
        repeat (5) tick();
        n_checks++;
        if (bus.state !== 3'd2) begin
            n_errors++; $display("FAIL start_waits: state=%0d expected 2", bus.state);
        end
`endif
    endtask

    initial begin
        bus.frame_tick = 1'b0;
        bus.launch     = 1'b0;
        bus.time_mode  = 1'b0;
        bus.max_score  = 5'd0;
        bus.time_out   = 1'b0;
        bus.left_hit   = 1'b0;
        bus.right_hit  = 1'b0;
        test_reset();
        test_launch_seq();
        test_score_mode();
        test_simultaneous();
        test_time_mode();
        test_launch_hold();
        test_reset_mid();
        test_saturation();
        test_start_serve();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pong_game_sequencer.md
Name: pong_game_sequencer

Overview:
Central game-flow controller for the two-player VGA pong core. Runs the menu → set → start → play → end_point → end_game sequence on the pixel clock, with launch edges and one-frame ticks as its inputs. Owns the score counters, serve side, countdown-timer control and ball/paddle reset strobes that the ball, paddle and renderer blocks consume. Replaces the loose per-block state decoding with one registered FSM.

Parameters:
SCORE_W, 5, width of score and max_score
HOLD_FRAMES, 60, frames spent in end_point before leaving it (1..255)
SERVE_FRAMES, 120, auto-serve delay in frames (used only with AUTO_SERVE_EN, 1..255)

Ports:
clk_pix  in  1  pixel clock (25 MHz)
reset  in  1  synchronous, active-high
frame_tick  in  1  one-cycle pulse per frame (x==0, y==480)
launch  in  1  raw launch button, asynchronous
time_mode  in  1  0 = score-limited game, 1 = time-limited game
max_score  in  SCORE_W  winning score in score mode
time_out  in  1  level from countdown timer, 1 = expired
left_hit  in  1  one-cycle pulse: ball reached left wall
right_hit  in  1  one-cycle pulse: ball reached right wall
state  out  3  0 menu, 1 set, 2 start, 3 play, 4 end_point, 5 end_game
score_p1  out  SCORE_W  player-1 score
score_p2  out  SCORE_W  player-2 score
serve_player  out  1  0 = p1 serves, 1 = p2 serves
obj_reset  out  1  one-cycle pulse: re-centre ball and paddles
play_en  out  1  high only in play; enables ball motion
time_en  out  1  play && time_mode
time_reset  out  1  one-cycle pulse: reload countdown timer
winner  out  2  00 none, 01 p1, 10 p2, 11 draw; valid in end_game

Behaviour:
- launch passes through a 2-flop synchronizer. launch_edge = 1 for one cycle on the synchronized 0→1 transition.
- Reset values: state=menu, scores=0, serve_player=0, obj_reset=0, play_en=0, time_en=0, time_reset=0, winner=00, frame counter=0.
- All transitions are registered. state changes on the cycle after the qualifying condition. Illegal encodings 6 and 7 go to menu on the next cycle.
- menu:
  - launch_edge → set.
- set:
  - launch_edge → start.
  - On exit, pulse time_reset, clear both scores, set serve_player=0.
- start:
  - obj_reset pulses on the first cycle of entry.
  - launch_edge → play.
- play:
  - right_hit → score_p1+1, serve_player=1, go to end_point.
  - else left_hit → score_p2+1, serve_player=0, go to end_point.
  - Simultaneous hits: right_hit wins, left_hit is dropped.
  - time_out=1 in time mode with no hit that cycle → end_game. A hit takes priority over time_out in the same cycle.
  - Hits and time_out are ignored in every state except play.
- end_point:
  - Counts frame_tick. After HOLD_FRAMES ticks, go to end_game if the match is over, otherwise to start.
  - Match over: (time_mode=0 and max_score≠0 and either score ≥ max_score), or (time_mode=1 and time_out=1).
  - launch is ignored here. The frame counter clears on every state change.
- end_game:
  - winner = higher score, 11 if scores are equal. Registered on entry and held.
  - launch_edge → menu. Scores are kept until the next set exit.
- Scores saturate at 2^SCORE_W−1; no wrap.
- max_score=0 in score mode means unlimited play.
- play_en and time_en are registered decodes of the next state, so they rise in the same cycle state becomes play.
- Synchronous reset mid-game returns to menu in one cycle and drops any pending pulse.

Optional Feature:
AUTO_SERVE_EN
- Defined: in start, SERVE_FRAMES frame_ticks without launch_edge trigger an automatic → play. launch_edge still serves immediately. The counter restarts on each entry to start.
- Undefined: start waits for launch_edge indefinitely; the counter logic is not built.

Test Plan:
- Reset, then launch edges at cycles 10, 50, 90 → state goes 0→1→2→3. Each change happens one cycle after the synchronized edge; time_reset pulses once; obj_reset pulses once.
- In play, time_mode=0, max_score=2: two right_hit pulses, each separated by a full end_point hold (HOLD_FRAMES=4) and a launch → score_p1=2, state=5, winner=01, serve_player=1.
- In play, right_hit and left_hit in the same cycle → only score_p1 increments; state=4.
- In play, time_mode=1: assert time_out with no hit → state=5 next cycle. With scores 3:3 → winner=11.
- Hold launch high for 1000 cycles in menu → exactly one transition, to set.
- Assert reset in end_point with score_p2=7 → next cycle state=0, scores=0, all strobes=0. With AUTO_SERVE_EN and SERVE_FRAMES=3: enter start, give no launch, send 3 frame_ticks → state=3.
